vote_window: RTL and testbench
==============================

VOTE_WINDOW -- requirements
Module: vote_window

Interface
REQ-001 SHALL have parameter WIN, default 8: sliding-window length in samples, legal range 2..15.
REQ-002 SHALL have parameter THR, default 5: alarm-entry threshold, legal range 2..WIN.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port vote_in  input  1  majority-vote result from the upstream combinational voter stage.
REQ-006 SHALL have port sample  input  1  strobe; vote_in is captured on any clock edge where sample=1.
REQ-007 SHALL have port clear  input  1  synchronous flush of window and state.
REQ-008 SHALL have port count  output  CW  number of 1s currently in the window, where CW = $clog2(WIN+1) (4 for the default).
REQ-009 SHALL have port win_full  output  1  window holds WIN valid samples.
REQ-010 SHALL have port alarm  output  1  high while the state is ALARM.
REQ-011 SHALL have port upd  output  1  one-cycle pulse marking the cycle in which count and alarm have just updated.

Function
REQ-012 SHALL keep a WIN-bit history register and a fill counter in the range 0..WIN.
REQ-013 SHALL, on a sample edge, shift vote_in into the history and increment fill, saturating at WIN.
REQ-014 SHALL compute the next count as count + vote_in - dropped, where dropped is the oldest history bit when fill==WIN and 0 otherwise; count never wraps.
REQ-015 SHALL update count, win_full, alarm and upd on the edge that captures the sample, so all are visible one cycle after sample is asserted.
REQ-016 SHALL drive upd=1 for exactly one cycle per accepted sample and 0 otherwise.
REQ-017 SHALL implement a state machine with states FILL, RUN and ALARM.
REQ-018 SHALL have the following FILL transitions: on the sample edge that makes fill==WIN, go to ALARM if next count >= THR, else RUN.
REQ-019 SHALL have the following RUN transition: go to ALARM on a sample edge where next count >= THR.
REQ-020 SHALL have the following ALARM transition: go to RUN on a sample edge where next count <= THR-2 (hysteresis; default: enter at 5, exit at 3).
REQ-021 SHALL hold alarm at 0 in FILL regardless of count.
REQ-022 SHALL leave all state unchanged in cycles where sample=0.
REQ-023 SHALL, when clear=1, next cycle set history=0, fill=0, count=0, win_full=0, alarm=0, upd=0 and state=FILL.
REQ-024 SHALL give clear priority when clear and sample are high together: the sample is discarded.
REQ-025 SHALL accept back-to-back samples (sample high on every cycle) with no throughput loss.

Reset
REQ-026 SHALL, while rst=1 and regardless of clk, force history=0, fill=0, count=0, win_full=0, alarm=0, upd=0 and state=FILL.
REQ-027 SHALL, on reset asserted mid-window, discard all history; the first sample after deassertion restarts filling from fill=0.
REQ-028 SHALL ignore sample on the first clock edge coincident with rst deassertion.

Structure
REQ-029 SHALL place the state enum (FILL, RUN, ALARM) and default WIN/THR localparams in a shared package vote_pkg.
REQ-030 SHALL implement the history shift register plus the dropped-bit/fill logic as sub-module vote_window_shreg, instantiated once; the FSM and count live in the top module.

Verification
REQ-031 SHALL cover: reset, then 8 samples of vote_in=1 -> count steps 1..8; win_full rises with the 8th; alarm=1 with upd after the 8th sample (state FILL->ALARM).
REQ-032 SHALL cover: full window of 1s, then samples of 0 -> count 7,6,5,4 keeps alarm=1; count 3 -> alarm=0.
REQ-033 SHALL cover: full window of pattern 1,0 repeated (count 4), then one sample 1 dropping a 0 -> count 5 and alarm rises.
REQ-034 SHALL cover: clear and sample high in the same cycle with count=6 -> next cycle count=0, fill=0, upd=0, alarm=0.
REQ-035 SHALL cover: rst pulse between clocks after 5 samples -> outputs zero immediately; 8 further samples are needed before win_full.
REQ-036 SHALL cover: sample toggled irregularly with gaps -> count and upd change only on sample edges; compare against a scoreboard popcount of the last 8 samples.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared definitions for the vote_window block: controller state encoding and
// default window/threshold sizes.
package vote_pkg;

  localparam int WIN_DEF = 8;  // samples held in the sliding window
  localparam int THR_DEF = 5;  // window popcount that raises the alarm

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ALARM = 2'd2
  } vote_state_e;

endpackage

// File: rtl/vote_window_shreg.sv
// Sliding-window history for vote_window.
// Holds the last WIN accepted votes (bit 0 newest) and a fill counter that
// saturates at WIN. 'dropped' is the vote that leaves the window on the next
// shift. It is only non-zero once the window is full.
//   clk, rst   : clock, async active-high reset
//   clear      : synchronous flush, wins over shift_en
//   shift_en   : shift bit_in into the history this cycle
//   bit_in     : vote to shift in
//   fill       : number of valid samples held, 0..WIN
//   dropped    : oldest valid sample, 0 while the window is still filling
module vote_window_shreg
  import vote_pkg::*;
#(
  parameter int  WIN = WIN_DEF,
  localparam int CW  = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          shift_en,
  input  logic          bit_in,
  output logic [CW-1:0] fill,
  output logic          dropped
);

  logic [WIN-1:0] hist_q, hist_d;
  logic [CW-1:0]  fill_q, fill_d;
  logic           full;

  assign full    = (fill_q == CW'(WIN));
  assign dropped = full ? hist_q[WIN-1] : 1'b0;
  assign fill    = fill_q;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = {hist_q[WIN-2:0], bit_in};
      if (!full) begin
        fill_d = fill_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/vote_window.sv
// Sliding-window vote counter with hysteretic alarm.
// Keeps a running count of 1s over the last WIN accepted votes. The alarm
// raises when the count reaches THR and drops when it falls to THR-2 or less.
// No alarm is raised until the window has filled once.
//   clk, rst  : clock, async active-high reset
//   vote_in   : vote from the upstream voter
//   sample    : capture vote_in on this edge
//   clear     : synchronous flush, beats a coincident sample
//   count     : number of 1s in the window
//   win_full  : window holds WIN samples
//   alarm     : state is ALARM
//   upd       : one-cycle pulse, count/alarm just updated for a sample
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FILL  | window not yet full; alarm held low
// ST_RUN   | window full, count below entry threshold (or hysteresis)
// ST_ALARM | window full, count reached THR and not yet down to THR-2
module vote_window
  import vote_pkg::*;
#(
  parameter int  WIN = WIN_DEF,
  parameter int  THR = THR_DEF,
  localparam int CW  = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vote_in,
  input  logic          sample,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          win_full,
  output logic          alarm,
  output logic          upd
);

  vote_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          upd_q, upd_d;
  logic          armed_q, armed_d;

  logic [CW-1:0] fill;
  logic          dropped;
  logic          accept;
  logic          fill_last;
  logic          enter_alarm;
  logic          exit_alarm;

  // armed_q is low for the first edge after reset, so a sample held high
  // across reset release is not taken on that edge.
  assign accept    = sample && armed_q && !clear;
  assign fill_last = (fill == CW'(WIN - 1));

  vote_window_shreg #(
    .WIN (WIN)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift_en (accept),
    .bit_in   (vote_in),
    .fill     (fill),
    .dropped  (dropped)
  );

  always_comb begin
    count_d = count_q;
    upd_d   = 1'b0;
    armed_d = 1'b1;
    if (clear) begin
      count_d = '0;
    end else if (accept) begin
      // dropped can only be 1 if that bit is already counted, so no underflow
      count_d = count_q + CW'(vote_in) - CW'(dropped);
      upd_d   = 1'b1;
    end
  end

  assign enter_alarm = (count_d >= CW'(THR));
  assign exit_alarm  = (count_d <= CW'(THR - 2));

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_FILL;
    end else if (accept) begin
      case (state_q)
        ST_FILL: begin
          if (fill_last) begin
            state_d = enter_alarm ? ST_ALARM : ST_RUN;
          end
        end
        ST_RUN: begin
          if (enter_alarm) begin
            state_d = ST_ALARM;
          end
        end
        ST_ALARM: begin
          if (exit_alarm) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      count_q <= '0;
      upd_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      upd_q   <= upd_d;
      armed_q <= armed_d;
    end
  end

  assign count    = count_q;
  assign win_full = (fill == CW'(WIN));
  assign alarm    = (state_q == ST_ALARM);
  assign upd      = upd_q;

endmodule

// File: tb/tb_vote_window.sv
module tb_vote_window;

  logic       clk = 1'b0;
  logic       rst;
  logic       vote_in;
  logic       sample;
  logic       clear;
  logic [3:0] count;
  logic       win_full;
  logic       alarm;
  logic       upd;

  vote_window dut (
    .clk      (clk),
    .rst      (rst),
    .vote_in  (vote_in),
    .sample   (sample),
    .clear    (clear),
    .count    (count),
    .win_full (win_full),
    .alarm    (alarm),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cnt;
    logic       full;
    logic       alm;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   n_push = 0;
  int   n_upd  = 0;

  // reference model for the irregular-sample sequence
  logic m_hist[$];
  int   m_state = 0;  // 0 fill, 1 run, 2 alarm
  int   m_cnt   = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every upd pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && upd) begin
      n_upd++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL upd_unexpected: got upd=1, expected no update (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("count", int'(count), int'(e.cnt));
        chk("win_full", int'(win_full), int'(e.full));
        chk("alarm", int'(alarm), int'(e.alm));
      end
    end
  end

  task automatic send(input logic v, input int ec, input logic ef, input logic ea);
    exp_t e;
    e.cnt  = 4'(ec);
    e.full = ef;
    e.alm  = ea;
    q.push_back(e);
    n_push++;
    vote_in = v;
    sample  = 1'b1;
    @(posedge clk);
    #1;
    sample  = 1'b0;
    vote_in = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_state = 0;
    m_cnt   = 0;
  endtask

  task automatic send_model(input logic v);
    logic full;
    m_hist.push_back(v);
    if (m_hist.size() > 8) void'(m_hist.pop_front());
    m_cnt = 0;
    foreach (m_hist[i]) m_cnt += int'(m_hist[i]);
    full = (m_hist.size() == 8);
    case (m_state)
      0: if (full) m_state = (m_cnt >= 5) ? 2 : 1;
      1: if (m_cnt >= 5) m_state = 2;
      default: if (m_cnt <= 3) m_state = 1;
    endcase
    send(v, m_cnt, full, m_state == 2);
  endtask

  int   c032 [5] = '{7, 6, 5, 4, 3};
  logic a032 [5] = '{1, 1, 1, 1, 0};
  int   c033 [8] = '{0, 1, 1, 2, 2, 3, 3, 4};
  logic v036 [15] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1};
  int   g036 [15] = '{0, 2, 1, 0, 3, 0, 1, 2, 0, 1, 3, 0, 2, 0, 1};

  initial begin
    rst     = 1'b1;
    sample  = 1'b0;
    clear   = 1'b0;
    vote_in = 1'b0;
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_win_full", int'(win_full), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_upd", int'(upd), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // eight 1s: count 1..8, full and alarm with the 8th
    for (int i = 1; i <= 8; i++) send(1'b1, i, i == 8, i == 8);

    // 0s drain the window; alarm holds down to 4 and drops at 3
    for (int i = 0; i < 5; i++) send(1'b0, c032[i], 1'b1, a032[i]);

    // 0,1 pattern gives 4; one more 1 drops a 0 and reaches 5
    do_clear();
    for (int i = 0; i < 8; i++) send(logic'(i % 2), c033[i], i == 7, 1'b0);
    send(1'b1, 5, 1'b1, 1'b1);

    // bring count to 6, then clear with a coincident sample
    send(1'b1, 5, 1'b1, 1'b1);
    send(1'b1, 6, 1'b1, 1'b1);
    clear   = 1'b1;
    sample  = 1'b1;
    vote_in = 1'b1;
    @(posedge clk);
    #1;
    clear   = 1'b0;
    sample  = 1'b0;
    vote_in = 1'b0;
    @(negedge clk);
    chk("clr_count", int'(count), 0);
    chk("clr_win_full", int'(win_full), 0);
    chk("clr_upd", int'(upd), 0);
    chk("clr_alarm", int'(alarm), 0);

    // five samples, reset pulse between clocks, then refill from empty
    for (int i = 1; i <= 5; i++) send(1'b1, i, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_upd", int'(upd), 0);
    chk("mid_rst_win_full", int'(win_full), 0);
    chk("mid_rst_alarm", int'(alarm), 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 8; i++) send(1'b1, i, i == 8, i == 8);

    // irregular sampling with gaps against the popcount model
    do_clear();
    model_reset();
    for (int i = 0; i < 15; i++) begin
      send_model(v036[i]);
      for (int g = 0; g < g036[i]; g++) begin
        @(posedge clk);
        @(negedge clk);
        chk("gap_count", int'(count), m_cnt);
        chk("gap_upd", int'(upd), 0);
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("upd_total", n_upd, n_push);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
